ahb_dma_copy_master: RTL
========================

// Module: ahb_dma_copy_master
// PURPOSE
//  AHB-Lite master engine copying LEN 32-bit words from SRC to DST, one SINGLE read then one SINGLE write per word.
//  Drives the DMA master port of the two-master AHB arbiter; HREADY low while the CPU owns the bus acts as grant-wait.
//  Keeps HTRANS=NONSEQ continuously during a job so the arbiter never hands the bus back mid-copy; HTRANS=IDLE releases.
// PARAMETERS
//  LEN_W      16       width of word-count input; max job = 2^LEN_W-1 words
//  HPROT_VAL  4'b0011  constant HPROT (data, privileged)
// PORTS
//  clk        in   1   clock
//  resetn     in   1   reset, asynchronous, active-low
//  start      in   1   1-cycle job request; sampled only in IDLE
//  src_addr   in   32  source byte address; bits[1:0] forced 0
//  dst_addr   in   32  destination byte address; bits[1:0] forced 0
//  len        in   LEN_W  number of words
//  busy       out  1   high from cycle after accepted start until done/err
//  done       out  1   1-cycle pulse: job completed without error
//  err        out  1   1-cycle pulse: job aborted on HRESP error
//  HADDR      out  32  AHB address
//  HBURST     out  3   constant 3'b000 (SINGLE)
//  HMASTLOCK  out  1   constant 0
//  HPROT      out  4   constant HPROT_VAL
//  HSIZE      out  3   constant 3'b010 (word)
//  HTRANS     out  2   2'b10 NONSEQ in address phases, 2'b00 otherwise
//  HWDATA     out  32  write data (registered read data)
//  HWRITE     out  1   1 in write address phase
//  HRDATA     in   32  read data
//  HREADY     in   1   phase completes when high
//  HRESP      in   1   error; valid only when HREADY=1 in a data phase
// BEHAVIOUR
//  Reset: state IDLE; busy/done/err=0; HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0; counters 0.
//  States: IDLE, RD, WR, LAST. Every non-IDLE state holds all outputs/registers while HREADY=0.
//  IDLE: start & len!=0 -> load sa=src, da=dst, cnt=len; -> RD. start & len==0 -> done pulse next cycle, no bus cycle.
//  RD : HADDR=sa, HWRITE=0, HTRANS=NONSEQ; also data phase of previous write (HWDATA=wbuf) if not first word.
//       On HREADY: sa+=4 -> WR.
//  WR : HADDR=da, HWRITE=1, HTRANS=NONSEQ; data phase of read. On HREADY: wbuf<=HRDATA, da+=4, cnt-=1;
//       cnt(before dec)>1 -> RD, else -> LAST.
//  LAST: HTRANS=IDLE, HWRITE=0, HWDATA=wbuf (final write data phase). On HREADY: done pulse, -> IDLE.
//  Error: HREADY=1 & HRESP=1 in any data phase (WR: read data; RD non-first or LAST: write data) -> err pulse,
//         HTRANS=IDLE next cycle, -> IDLE; current address phase abandoned, no further transfers.
//  Throughput zero-wait: 2 cycles/word + 1 LAST cycle; done asserted cycle after LAST completes.
//  Address arithmetic modulo 2^32 (wraps 0xFFFFFFFC -> 0x0); cnt never underflows.
//  start while busy ignored; done and err never asserted together; busy drops the cycle done/err pulses.
//  HRESP with HREADY=0 (e.g. while not granted) is ignored.
//  resetn low mid-job: immediate abort, all outputs to reset values, no done/err pulse.
// TESTING
//  Copy len=3 src=0x1000 dst=0x2000 zero-wait -> HADDR 1000,2000,1004,2004,1008,2008 HTRANS=10, then IDLE; done 8 cycles after start.
//  Same job, HREADY=0 for 5 cycles in first RD (grant wait) -> outputs frozen, HADDR=0x1000 held, result identical, done 5 cycles later.
//  len=0 -> done pulse next cycle, HTRANS stays 00, busy never high.
//  Read word 2 returns HRESP=1,HREADY=1 -> err pulse, HTRANS=00 next cycle, only 1 write issued, no done.
//  start pulsed again while busy with different src -> ignored; original addresses continue.
//  resetn low during WR of word 2 -> HTRANS=00, busy=0 immediately; new start after release copies correctly.

Source files
------------

// File: rtl/ahb_dma_copy_master.sv
// AHB-Lite DMA copy master: moves len words from src to dst as alternating SINGLE read/write transfers.
// HTRANS stays NONSEQ for the whole job so the two-master arbiter keeps the grant until the final data phase.
module ahb_dma_copy_master #(
  parameter int unsigned LEN_W     = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [2:0]       HBURST,
  output logic             HMASTLOCK,
  output logic [3:0]       HPROT,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic [31:0]      HWDATA,
  output logic             HWRITE,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam int unsigned AW           = 32;
  localparam logic [AW-1:0] WORD_STEP  = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
  localparam logic [1:0] TRANS_IDLE    = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_LAST} state_t;

  state_t           state, state_n;
  logic [AW-1:0]    sa, sa_n, da, da_n, haddr_n, wbuf_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             first, first_n;
  logic             busy_n, done_n, err_n, hwrite_n;
  logic [1:0]       htrans_n;
  logic             data_err;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign HSIZE     = 3'b010;

  // Error response only counts in a cycle that is actually a data phase and completes.
  assign data_err = HREADY && HRESP &&
                    ((state == S_RD && !first) || state == S_WR || state == S_LAST);

  // State and datapath registers; wbuf is presented directly as HWDATA.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      sa     <= '0;
      da     <= '0;
      cnt    <= '0;
      first  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      HADDR  <= '0;
      HTRANS <= TRANS_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      da     <= da_n;
      cnt    <= cnt_n;
      first  <= first_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
      HADDR  <= haddr_n;
      HTRANS <= htrans_n;
      HWRITE <= hwrite_n;
      HWDATA <= wbuf_n;
    end
  end

  // Next-state decode; every non-idle state stalls while HREADY is low.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start && len != '0) state_n = S_RD;
      S_RD:   if (HREADY) state_n = data_err ? S_IDLE : S_WR;
      S_WR:   if (HREADY) state_n = data_err ? S_IDLE :
                                    ((cnt > LEN_W'(1)) ? S_RD : S_LAST);
      S_LAST: if (HREADY) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of datapath and bus outputs.
  always_comb begin
    sa_n     = sa;
    da_n     = da;
    cnt_n    = cnt;
    first_n  = first;
    wbuf_n   = HWDATA;
    haddr_n  = HADDR;
    htrans_n = HTRANS;
    hwrite_n = HWRITE;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (data_err) begin
      err_n    = 1'b1;
      busy_n   = 1'b0;
      htrans_n = TRANS_IDLE;
      hwrite_n = 1'b0;
      haddr_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_n = 1'b1;
            end else begin
              sa_n     = src_addr & ALIGN_MASK;
              da_n     = dst_addr & ALIGN_MASK;
              cnt_n    = len;
              first_n  = 1'b1;
              busy_n   = 1'b1;
              haddr_n  = src_addr & ALIGN_MASK;
              htrans_n = TRANS_NONSEQ;
              hwrite_n = 1'b0;
            end
          end
        end
        S_RD: begin
          if (HREADY) begin
            sa_n     = sa + WORD_STEP;
            haddr_n  = da;
            hwrite_n = 1'b1;
          end
        end
        S_WR: begin
          if (HREADY) begin
            wbuf_n  = HRDATA;
            da_n    = da + WORD_STEP;
            cnt_n   = cnt - LEN_W'(1);
            first_n = 1'b0;
            hwrite_n = 1'b0;
            if (cnt > LEN_W'(1)) begin
              haddr_n = sa;
            end else begin
              htrans_n = TRANS_IDLE;
              haddr_n  = '0;
            end
          end
        end
        S_LAST: begin
          if (HREADY) begin
            done_n = 1'b1;
            busy_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
